// File: rtl/aes_inv_key_expand.sv
// rtl/aes_inv_key_expand.sv - AES-128 round-key store served in reverse order for decryption

// AES forward S-box: GF(2^8) inverse (x^254) followed by the affine transform
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain to x^254, which is the inverse for non-zero inputs and 0 for 0
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// Expands the cipher key once, then hands out round keys 10 down to 0 on each adv
module aes_inv_key_expand #(
  parameter int NR   = 10,
  parameter int RK_W = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [RK_W-1:0] key,
  input  logic            adv,
  output logic            busy,
  output logic            kvalid,
  output logic [RK_W-1:0] rk_out,
  output logic [3:0]      ridx,
  output logic            last
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            kvalid_q, kvalid_d;
  logic            last_q, last_d;
  logic [3:0]      ridx_q, ridx_d;
  logic [RK_W-1:0] rk_out_q, rk_out_d;
  logic [RK_W-1:0] w_q, w_d;

  // Round-key storage; contents are only meaningful once written by an expansion
  logic [RK_W-1:0] rk_q [0:NR];
  logic            rk_we;
  logic [3:0]      rk_waddr;
  logic [RK_W-1:0] rk_wdata;

  logic [31:0]     w0_p, w1_p, w2_p, w3_p;
  logic [31:0]     sub_word, t_word;
  logic [31:0]     nw0, nw1, nw2, nw3;
  logic [7:0]      rcon;
  logic [RK_W-1:0] w_next;

  assign w0_p = w_q[127:96];
  assign w1_p = w_q[95:64];
  assign w2_p = w_q[63:32];
  assign w3_p = w_q[31:0];

  // SubWord(RotWord(w3)): rotation is just a byte re-wiring into the S-boxes
  aes_sbox u_sbox3 (.in_byte(w3_p[23:16]), .out_byte(sub_word[31:24]));
  aes_sbox u_sbox2 (.in_byte(w3_p[15:8]),  .out_byte(sub_word[23:16]));
  aes_sbox u_sbox1 (.in_byte(w3_p[7:0]),   .out_byte(sub_word[15:8]));
  aes_sbox u_sbox0 (.in_byte(w3_p[31:24]), .out_byte(sub_word[7:0]));

  // Round constant for the round currently being produced
  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // One forward key-schedule round from the previous round key held in w_q
  always_comb begin
    t_word = sub_word ^ {rcon, 24'h000000};
    nw0    = w0_p ^ t_word;
    nw1    = w1_p ^ nw0;
    nw2    = w2_p ^ nw1;
    nw3    = w3_p ^ nw2;
    w_next = {nw0, nw1, nw2, nw3};
  end

  // Control: ld restarts from anywhere, EXPAND fills storage, SERVE walks it downward
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    kvalid_d = kvalid_q;
    last_d   = last_q;
    ridx_d   = ridx_q;
    rk_out_d = rk_out_q;
    w_d      = w_q;
    rk_we    = 1'b0;
    rk_waddr = 4'd0;
    rk_wdata = w_next;

    if (ld) begin
      state_d  = EXPAND;
      cnt_d    = 4'd1;
      busy_d   = 1'b1;
      kvalid_d = 1'b0;
      last_d   = 1'b0;
      w_d      = key;
      rk_we    = 1'b1;
      rk_waddr = 4'd0;
      rk_wdata = key;
    end else begin
      case (state_q)
        EXPAND: begin
          w_d      = w_next;
          rk_we    = 1'b1;
          rk_waddr = cnt_q;
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == LAST_RND) begin
            // Final round key bypasses storage so it is presented on the same edge
            state_d  = SERVE;
            cnt_d    = 4'd0;
            busy_d   = 1'b0;
            kvalid_d = 1'b1;
            ridx_d   = LAST_RND;
            rk_out_d = w_next;
            last_d   = 1'b0;
          end
        end
        SERVE: begin
          if (adv && kvalid_q) begin
            if (ridx_q == 4'd0) begin
              // Wrap so the next block reuses the schedule without re-expansion
              ridx_d   = LAST_RND;
              rk_out_d = rk_q[NR];
              last_d   = 1'b0;
            end else begin
              ridx_d   = ridx_q - 4'd1;
              rk_out_d = rk_q[ridx_q - 4'd1];
              last_d   = (ridx_q == 4'd1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      kvalid_q <= 1'b0;
      last_q   <= 1'b0;
      ridx_q   <= 4'd0;
      rk_out_q <= '0;
      w_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      kvalid_q <= kvalid_d;
      last_q   <= last_d;
      ridx_q   <= ridx_d;
      rk_out_q <= rk_out_d;
      w_q      <= w_d;
    end
  end

  // Round-key storage write port (intentionally not reset)
  always_ff @(posedge clk) begin
    if (rk_we) rk_q[rk_waddr] <= rk_wdata;
  end

  assign busy   = busy_q;
  assign kvalid = kvalid_q;
  assign rk_out = rk_out_q;
  assign ridx   = ridx_q;
  assign last   = last_q;

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// tb/tb_aes_inv_key_expand.sv - self-checking bench for aes_inv_key_expand

module tb_aes_inv_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld;
  logic [127:0] key;
  logic         adv;
  logic         busy;
  logic         kvalid;
  logic [127:0] rk_out;
  logic [3:0]   ridx;
  logic         last;

  aes_inv_key_expand dut (
    .clk(clk), .rst(rst), .ld(ld), .key(key), .adv(adv),
    .busy(busy), .kvalid(kvalid), .rk_out(rk_out), .ridx(ridx), .last(last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb  [0:255];
  logic [127:0] mrk [0:10];

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk10;
    logic [127:0] rk1;
  } vec_t;

  vec_t vecs [0:2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box table from walking generator 3 and its inverse through the field
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  // Word-oriented FIPS-197 key expansion into mrk[0..10]
  task automatic model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k);
    ld  = 1'b1;
    key = k;
    step();
    ld  = 1'b0;
  endtask

  // Waits (bounded) for kvalid after a load and checks latency and busy span
  task automatic wait_kvalid(input string tag);
    int n, nb;
    n  = 0;
    nb = busy ? 1 : 0;
    while (!kvalid && n < 20) begin
      step();
      n++;
      if (!kvalid && busy) nb++;
    end
    chk({tag, "_latency"}, 128'(n), 128'd10);
    chk({tag, "_busy_cycles"}, 128'(nb), 128'd10);
    chk({tag, "_busy_low"}, 128'(busy), 128'd0);
    chk({tag, "_ridx10"}, 128'(ridx), 128'd10);
    chk({tag, "_rk10"}, rk_out, mrk[10]);
  endtask

  task automatic adv_pulse();
    adv = 1'b1;
    step();
    adv = 1'b0;
  endtask

  // Ten advances down to round 0, then one more to wrap back to round 10
  task automatic sweep(input string tag, input logic [127:0] k, input logic [127:0] rk1);
    for (int r = 9; r >= 0; r--) begin
      adv_pulse();
      chk({tag, "_ridx"}, 128'(ridx), 128'(r));
      chk({tag, "_rk"}, rk_out, mrk[r]);
      chk({tag, "_last"}, 128'(last), 128'(r == 0));
      if (r == 1) chk({tag, "_rk1"}, rk_out, rk1);
      if (r == 0) chk({tag, "_rk0_key"}, rk_out, k);
    end
    adv_pulse();
    chk({tag, "_wrap_ridx"}, 128'(ridx), 128'd10);
    chk({tag, "_wrap_rk"}, rk_out, mrk[10]);
    chk({tag, "_wrap_last"}, 128'(last), 128'd0);
    chk({tag, "_wrap_kvalid"}, 128'(kvalid), 128'd1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k1, k2;
    int gap;

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h13111d7fe3944a17f307a78b4d2b30c5,
                128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[2] = '{128'h00000000000000000000000000000000,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                128'h62636363626363636263636362636363};

    rst = 1'b0; ld = 1'b0; adv = 1'b0; key = '0;
    build_sbox();

    #2;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_kvalid", 128'(kvalid), 128'd0);
    chk("rst_ridx", 128'(ridx), 128'd0);
    chk("rst_last", 128'(last), 128'd0);
    chk("rst_rk_out", rk_out, 128'd0);
    step();
    rst = 1'b1;
    step();

    adv_pulse();
    chk("idle_adv_kvalid", 128'(kvalid), 128'd0);
    chk("idle_adv_rk_out", rk_out, 128'd0);

    for (int v = 0; v < 3; v++) begin
      model(vecs[v].key);
      do_load(vecs[v].key);
      chk("vec_busy_after_ld", 128'(busy), 128'd1);
      wait_kvalid("vec");
      chk("vec_rk10_table", rk_out, vecs[v].rk10);
      sweep("vec", vecs[v].key, vecs[v].rk1);
    end

    k1 = rnd128();
    model(k1);
    do_load(k1);
    wait_kvalid("gap");
    for (int r = 9; r >= 0; r--) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        chk("gap_hold_rk", rk_out, mrk[r+1]);
        chk("gap_hold_ridx", 128'(ridx), 128'(r+1));
      end
      adv_pulse();
      chk("gap_ridx", 128'(ridx), 128'(r));
      chk("gap_rk", rk_out, mrk[r]);
    end

    do_load(rnd128());
    repeat (4) step();
    rst = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_kvalid", 128'(kvalid), 128'd0);
    chk("arst_ridx", 128'(ridx), 128'd0);
    chk("arst_last", 128'(last), 128'd0);
    chk("arst_rk_out", rk_out, 128'd0);
    step();
    rst = 1'b1;
    step();
    adv_pulse();
    adv_pulse();
    chk("post_rst_adv_kvalid", 128'(kvalid), 128'd0);
    chk("post_rst_adv_busy", 128'(busy), 128'd0);
    chk("post_rst_adv_ridx", 128'(ridx), 128'd0);
    chk("post_rst_adv_rk", rk_out, 128'd0);

    k1 = rnd128();
    k2 = rnd128();
    model(k1);
    do_load(k1);
    wait_kvalid("ldadv_first");
    repeat (6) adv_pulse();
    chk("ldadv_ridx4", 128'(ridx), 128'd4);
    chk("ldadv_rk4", rk_out, mrk[4]);
    ld = 1'b1; adv = 1'b1; key = k2;
    step();
    ld = 1'b0; adv = 1'b0;
    chk("ldadv_kvalid", 128'(kvalid), 128'd0);
    chk("ldadv_busy", 128'(busy), 128'd1);
    chk("ldadv_last", 128'(last), 128'd0);
    model(k2);
    wait_kvalid("ldadv_second");
    sweep("ldadv", k2, mrk[1]);

    k1 = rnd128();
    k2 = rnd128();
    do_load(k1);
    repeat (5) step();
    chk("restart_busy", 128'(busy), 128'd1);
    model(k2);
    do_load(k2);
    wait_kvalid("restart");
    sweep("restart", k2, mrk[1]);

    for (int i = 0; i < 3; i++) begin
      k1 = rnd128();
      model(k1);
      do_load(k1);
      wait_kvalid("rand");
      sweep("rand", k1, mrk[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_inv_key_expand.md
Name: aes_inv_key_expand

Overview:
AES-128 decryption round-key source. It expands a 128-bit cipher key forward, stores all 11 round keys, then serves them in reverse order (round 10 down to round 0) to the inverse-cipher datapath, one key per handshake. It is the consumer-side counterpart of the encryption core's forward key schedule (w0..w3) and sits between key load and the decryption round engine.

Parameters:
NR  10  number of rounds; only 10 (AES-128) is supported, and the storage depth is NR+1
RK_W  128  round-key width; fixed at 128

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
ld  input  1  load pulse; samples key and starts expansion
key  input  128  cipher key; w0 = key[127:96], w3 = key[31:0]
adv  input  1  consumer has taken rk_out; step to the next lower round
busy  output  1  expansion in progress
kvalid  output  1  rk_out and ridx are valid
rk_out  output  128  round key for round ridx (registered)
ridx  output  4  round index of rk_out, 10..0
last  output  1  high when kvalid is high and ridx==0

Behaviour:
- One clock domain: clk. Reset: rst is asynchronous and active-low.
- Reset (rst=0, asynchronous): state=IDLE, busy=0, kvalid=0, rk_out=0, ridx=0, last=0, cnt=0. Round-key storage is not reset; its contents are don't-care until written.
- States: IDLE, EXPAND, SERVE.
- ld=1 at an edge, in any state:
  - rk[0]<=key, cnt<=1, state<=EXPAND, busy<=1, kvalid<=0, last<=0.
  - ld mid-EXPAND or mid-SERVE aborts the current operation and restarts.
  - ld has priority over adv.
- EXPAND, one round per clock, cnt=1..10:
  - t = SubWord(RotWord(w3_prev)) ^ {rcon[cnt],24'h0}
  - w0 = w0_prev^t; w1 = w1_prev^w0; w2 = w2_prev^w1; w3 = w3_prev^w2
  - rk[cnt] <= {w0,w1,w2,w3}
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36
  - SubWord uses four instances of the codebase's existing aes_sbox.
- At the edge that writes rk[10]: state<=SERVE, busy<=0, kvalid<=1, ridx<=10, rk_out<=computed rk[10] (bypass, not a storage read).
  - Timing: ld sampled at edge E0; kvalid is high after edge E10, a latency of 10 clocks.
- SERVE:
  - adv=1 at an edge with kvalid=1 and ld=0: ridx<=ridx-1 and rk_out<=rk[ridx-1].
  - If ridx==0, adv wraps: ridx<=10 and rk_out<=rk[10]. This lets the next ciphertext block reuse the same keys without re-expansion. kvalid stays 1.
- last = kvalid && (ridx==0), registered in step with ridx.
- adv while kvalid=0 (IDLE or EXPAND) is ignored.
- rk_out changes only on ld, adv, or entry into SERVE. It holds otherwise.
- IDLE is reached only through reset. There is no path back to IDLE from EXPAND or SERVE.

Test Plan:
1. Reset mid-operation: assert rst=0 during EXPAND at cnt=5 -> busy, kvalid, ridx, last and rk_out read 0 immediately, before the next clock edge; after release, adv is ignored until the next ld.
2. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, ld one cycle -> busy=1 for 10 cycles; kvalid rises after E10 with ridx=10 and rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
3. Same key, 10 adv pulses -> ridx steps 9..0. At ridx=1, rk_out=a0fafe1788542cb123a339392a6c7605. At ridx=0, rk_out=key and last=1. An 11th adv -> ridx=10, rk_out=d014f9a8..., last=0.
4. Key 000102030405060708090a0b0c0d0e0f -> at ridx=10, rk_out=13111d7fe3944a17f307a78b4d2b30c5. Gapped adv (random 0-3 idle cycles between pulses) -> rk_out holds steady between pulses.
5. ld asserted at SERVE ridx=4 together with adv=1 -> ld wins: kvalid=0, busy=1, and a fresh expansion delivers the new key's rk[10] 10 cycles later.
6. ld re-asserted at EXPAND cnt=6 with a different key -> the output reflects only the new key; kvalid rises 10 cycles after the second ld.
